// File: rtl/gci_std_display_vram_reader.sv
// gci_std_display_vram_reader
// Scans the VRAM frame in linear address order, issues pipelined read
// requests and buffers the returned pixels in a credit-limited FIFO that
// the display timing drains one pixel per request.
//
// Handshake semantics:
//   VRAM request side: oVRAM_READ_REQ/oVRAM_READ_ADDR are registered and
//   hold stable while iVRAM_WAIT is high; a request is accepted on a rising
//   clock edge where oVRAM_READ_REQ && !iVRAM_WAIT. Returns arrive in
//   request order, one per cycle with iVRAM_READ_VALID, and cannot be
//   stalled. Display side: iDISP_REQ pops the FIFO head; the pixel shows on
//   oDISP_DATA with oDISP_VALID one cycle later (no same-cycle bypass).
// oDEBUG_STATE mirrors the control state (0 IDLE, 1 RUN, 2 DRAIN).
module gci_std_display_vram_reader #(
    parameter int P_PIXELS       = 307200,
    parameter int P_FIFO_DEPTH   = 16,
    parameter int P_FIFO_DEPTH_N = 4
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iDISP_ENA,
    input  logic        iDISP_VSYNC,
    input  logic        iDISP_REQ,
    output logic        oDISP_VALID,
    output logic [15:0] oDISP_DATA,
    output logic        oDISP_UNDERRUN,
    output logic        oVRAM_READ_REQ,
    output logic [18:0] oVRAM_READ_ADDR,
    input  logic        iVRAM_WAIT,
    input  logic        iVRAM_READ_VALID,
    input  logic [15:0] iVRAM_READ_DATA,
    output logic        oERR_SPURIOUS,
    output logic [1:0]  oDEBUG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [18:0]               L_FRAME_END = 19'(P_PIXELS);
    localparam logic [P_FIFO_DEPTH_N+1:0] L_DEPTH_EXT = (P_FIFO_DEPTH_N+2)'(P_FIFO_DEPTH);
    localparam logic [P_FIFO_DEPTH_N:0]   L_CNT_ONE   = (P_FIFO_DEPTH_N+1)'(1);
    localparam logic [P_FIFO_DEPTH_N-1:0] L_PTR_ONE   = (P_FIFO_DEPTH_N)'(1);

    // Registered state
    state_t                    r_state;
    logic [18:0]               r_addr;
    logic [P_FIFO_DEPTH_N:0]   r_outstanding;
    logic [P_FIFO_DEPTH_N:0]   r_fifo_count;
    logic [P_FIFO_DEPTH_N-1:0] r_wptr;
    logic [P_FIFO_DEPTH_N-1:0] r_rptr;
    logic [15:0]               r_mem [0:P_FIFO_DEPTH-1];
    logic                      r_req;
    logic                      r_disp_valid;
    logic [15:0]               r_disp_data;
    logic                      r_underrun;
    logic                      r_spurious;
    logic                      r_vsync_seen;

    // Per-cycle events and next-state values
    logic                      w_accept;
    logic                      w_ret;
    logic                      w_spurious;
    logic                      w_pop;
    logic                      w_empty_req;
    logic                      w_push;
    logic                      w_flush;
    logic                      w_req_next;
    logic                      w_vsync_seen_next;
    state_t                    w_state_next;
    logic [18:0]               w_addr_next;
    logic [P_FIFO_DEPTH_N:0]   w_outstanding_next;
    logic [P_FIFO_DEPTH_N:0]   w_fifo_count_next;
    logic [P_FIFO_DEPTH_N+1:0] w_credit_sum;

    assign w_accept    = r_req && !iVRAM_WAIT;
    assign w_ret       = iVRAM_READ_VALID && (r_outstanding != '0);
    assign w_spurious  = iVRAM_READ_VALID && (r_outstanding == '0);
    assign w_pop       = iDISP_REQ && (r_fifo_count != '0);
    assign w_empty_req = iDISP_REQ && (r_fifo_count == '0);

    assign w_outstanding_next = r_outstanding
                              + (w_accept ? L_CNT_ONE : '0)
                              - (w_ret    ? L_CNT_ONE : '0);

    // Next-state decode: vsync restarts the scan, and a frame restart with
    // reads still in flight detours through DRAIN so stale pixels are dropped.
    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = w_accept ? (r_addr + 19'd1) : r_addr;
        w_flush           = 1'b0;
        w_vsync_seen_next = r_vsync_seen;
        case (r_state)
            S_IDLE: begin
                if (iDISP_VSYNC && iDISP_ENA) begin
                    w_addr_next  = '0;
                    w_flush      = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (iDISP_VSYNC) begin
                    w_addr_next = '0;
                    w_flush     = 1'b1;
                end
                if (!iDISP_ENA || (iDISP_VSYNC && (w_outstanding_next != '0))) begin
                    w_state_next      = S_DRAIN;
                    w_vsync_seen_next = iDISP_VSYNC;
                end
            end
            S_DRAIN: begin
                if (iDISP_VSYNC) begin
                    w_addr_next       = '0;
                    w_flush           = 1'b1;
                    w_vsync_seen_next = 1'b1;
                end
                if (w_outstanding_next == '0) begin
                    w_state_next      = (iDISP_ENA && (r_vsync_seen || iDISP_VSYNC)) ? S_RUN : S_IDLE;
                    w_vsync_seen_next = 1'b0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Returned data only enters the FIFO while scanning and not being flushed
    assign w_push = w_ret && (r_state == S_RUN) && !w_flush;

    assign w_fifo_count_next = w_flush ? '0
                             : (r_fifo_count
                                + (w_push ? L_CNT_ONE : '0)
                                - (w_pop  ? L_CNT_ONE : '0));

    // Credits: buffered plus in-flight pixels never exceed the FIFO depth
    assign w_credit_sum = {1'b0, w_fifo_count_next} + {1'b0, w_outstanding_next};
    assign w_req_next   = (w_state_next == S_RUN)
                       && (w_addr_next < L_FRAME_END)
                       && (w_credit_sum < L_DEPTH_EXT);

    // Pixel storage; contents are qualified by the pointers and need no reset
    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_mem[r_wptr] <= iVRAM_READ_DATA;
        end
    end

    // Control state, counters, pointers and registered outputs
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_outstanding <= '0;
            r_fifo_count  <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_req         <= 1'b0;
            r_disp_valid  <= 1'b0;
            r_disp_data   <= '0;
            r_underrun    <= 1'b0;
            r_spurious    <= 1'b0;
            r_vsync_seen  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_addr        <= w_addr_next;
            r_outstanding <= w_outstanding_next;
            r_fifo_count  <= w_fifo_count_next;
            r_vsync_seen  <= w_vsync_seen_next;
            r_req         <= w_req_next;
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + L_PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + L_PTR_ONE;
                end
            end
            r_disp_valid <= w_pop;
            if (w_pop) begin
                r_disp_data <= r_mem[r_rptr];
            end
            if (w_flush) begin
                r_underrun <= 1'b0;
            end else if (w_empty_req) begin
                r_underrun <= 1'b1;
            end
            if (w_spurious) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign oDISP_VALID     = r_disp_valid;
    assign oDISP_DATA      = r_disp_data;
    assign oDISP_UNDERRUN  = r_underrun;
    assign oVRAM_READ_REQ  = r_req;
    assign oVRAM_READ_ADDR = r_addr;
    assign oERR_SPURIOUS   = r_spurious;
    assign oDEBUG_STATE    = r_state;

endmodule

// File: tb/tb_gci_std_display_vram_reader.sv
// Directed bench for gci_std_display_vram_reader with a reduced frame size.
// A small VRAM model answers accepted reads after a programmable latency;
// popped pixels are scored against an expected queue.
module tb_gci_std_display_vram_reader;

    localparam int P_PIX = 48;
    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_RUN   = 32'd1;
    localparam logic [31:0] ST_DRAIN = 32'd2;

    // Clock and DUT signals
    logic        clk = 1'b0;
    logic        iRESET;
    logic        iDISP_ENA;
    logic        iDISP_VSYNC;
    logic        iDISP_REQ;
    logic        oDISP_VALID;
    logic [15:0] oDISP_DATA;
    logic        oDISP_UNDERRUN;
    logic        oVRAM_READ_REQ;
    logic [18:0] oVRAM_READ_ADDR;
    logic        iVRAM_WAIT;
    logic        iVRAM_READ_VALID;
    logic [15:0] iVRAM_READ_DATA;
    logic        oERR_SPURIOUS;
    logic [1:0]  oDEBUG_STATE;

    always #5 clk = ~clk;

    gci_std_display_vram_reader #(.P_PIXELS(P_PIX)) dut (
        .iCLOCK          (clk),
        .iRESET          (iRESET),
        .iDISP_ENA       (iDISP_ENA),
        .iDISP_VSYNC     (iDISP_VSYNC),
        .iDISP_REQ       (iDISP_REQ),
        .oDISP_VALID     (oDISP_VALID),
        .oDISP_DATA      (oDISP_DATA),
        .oDISP_UNDERRUN  (oDISP_UNDERRUN),
        .oVRAM_READ_REQ  (oVRAM_READ_REQ),
        .oVRAM_READ_ADDR (oVRAM_READ_ADDR),
        .iVRAM_WAIT      (iVRAM_WAIT),
        .iVRAM_READ_VALID(iVRAM_READ_VALID),
        .iVRAM_READ_DATA (iVRAM_READ_DATA),
        .oERR_SPURIOUS   (oERR_SPURIOUS),
        .oDEBUG_STATE    (oDEBUG_STATE)
    );

    // Scoreboard and VRAM model state
    int          checks = 0;
    int          errors = 0;
    int          cur = 0;
    int          lat = 2;
    bit          vram_auto = 1'b1;
    logic [18:0] due_a[$];
    int          due_t[$];
    logic [18:0] req_log[$];
    logic [15:0] exp_q[$];

    function automatic logic [15:0] vram_word(input logic [18:0] a);
        return {a[7:0] ^ 8'h3C, ~a[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: the VRAM model acts on the inputs about to be sampled,
    // then the pop monitor scores any pixel delivered by that edge.
    task automatic cyc();
        logic acc;
        acc = oVRAM_READ_REQ && !iVRAM_WAIT;
        if (vram_auto) begin
            if (due_t.size() != 0 && due_t[0] <= cur) begin
                iVRAM_READ_VALID = 1'b1;
                iVRAM_READ_DATA  = vram_word(due_a[0]);
                void'(due_a.pop_front());
                void'(due_t.pop_front());
            end else begin
                iVRAM_READ_VALID = 1'b0;
                iVRAM_READ_DATA  = 16'h0000;
            end
        end
        if (acc) begin
            due_a.push_back(oVRAM_READ_ADDR);
            due_t.push_back(cur + lat);
            req_log.push_back(oVRAM_READ_ADDR);
        end
        @(negedge clk);
        cur++;
        if (oDISP_VALID) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 32'(oDISP_VALID), 32'd0);
            else chk("pixel", 32'(oDISP_DATA), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic pulse_vsync();
        iDISP_VSYNC = 1'b1;
        exp_q.delete();
        for (int i = 0; i < P_PIX; i++) exp_q.push_back(vram_word(19'(i)));
        req_log.delete();
        cyc();
        iDISP_VSYNC = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},    32'(oDISP_VALID),     32'd0);
        chk({tag, "_data"},     32'(oDISP_DATA),      32'd0);
        chk({tag, "_underrun"}, 32'(oDISP_UNDERRUN),  32'd0);
        chk({tag, "_req"},      32'(oVRAM_READ_REQ),  32'd0);
        chk({tag, "_addr"},     32'(oVRAM_READ_ADDR), 32'd0);
        chk({tag, "_spurious"}, 32'(oERR_SPURIOUS),   32'd0);
        chk({tag, "_state"},    32'(oDEBUG_STATE),    ST_IDLE);
    endtask

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        iRESET = 1'b1;
        iDISP_ENA = 1'b0;
        iDISP_VSYNC = 1'b0;
        iDISP_REQ = 1'b0;
        iVRAM_WAIT = 1'b0;
        iVRAM_READ_VALID = 1'b0;
        iVRAM_READ_DATA = 16'h0000;

        // Reset state
        cyc();
        cyc();
        check_all_zero("reset");
        iRESET = 1'b0;
        cyc();
        chk("post_reset_state", 32'(oDEBUG_STATE), ST_IDLE);
        chk("post_reset_req", 32'(oVRAM_READ_REQ), 32'd0);

        // Spurious return while idle, then a pop from the empty FIFO
        vram_auto = 1'b0;
        iVRAM_READ_VALID = 1'b1;
        iVRAM_READ_DATA = 16'hDEAD;
        cyc();
        iVRAM_READ_VALID = 1'b0;
        vram_auto = 1'b1;
        chk("spurious_set", 32'(oERR_SPURIOUS), 32'd1);
        iDISP_REQ = 1'b1;
        cyc();
        iDISP_REQ = 1'b0;
        chk("spurious_fifo_empty_valid", 32'(oDISP_VALID), 32'd0);
        chk("spurious_fifo_empty_underrun", 32'(oDISP_UNDERRUN), 32'd1);

        // Steady frame: pop every 4th cycle
        iDISP_ENA = 1'b1;
        pulse_vsync();
        chk("frame_state", 32'(oDEBUG_STATE), ST_RUN);
        chk("frame_underrun_clr", 32'(oDISP_UNDERRUN), 32'd0);
        chk("frame_first_req", 32'(oVRAM_READ_REQ), 32'd1);
        chk("frame_first_addr", 32'(oVRAM_READ_ADDR), 32'd0);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            iDISP_REQ = (i % 4 == 3);
            cyc();
        end
        iDISP_REQ = 1'b0;
        cyc();
        cyc();
        chk("frame_all_popped", 32'(exp_q.size()), 32'd0);
        chk("frame_req_count", 32'(req_log.size()), 32'(P_PIX));
        for (int k = 0; k < P_PIX; k++) begin
            if (k < req_log.size()) chk("frame_addr_order", 32'(req_log[k]), 32'(k));
        end
        chk("frame_underrun", 32'(oDISP_UNDERRUN), 32'd0);
        chk("frame_end_req", 32'(oVRAM_READ_REQ), 32'd0);
        chk("frame_end_addr", 32'(oVRAM_READ_ADDR), 32'(P_PIX));
        chk("frame_end_state", 32'(oDEBUG_STATE), ST_RUN);

        // Underrun: pop the cycle after vsync
        pulse_vsync();
        iDISP_REQ = 1'b1;
        cyc();
        iDISP_REQ = 1'b0;
        chk("underrun_valid", 32'(oDISP_VALID), 32'd0);
        chk("underrun_flag", 32'(oDISP_UNDERRUN), 32'd1);

        // Backpressure: no pops, credits run out at 16
        for (int i = 0; i < 30; i++) cyc();
        chk("bp_req_count", 32'(req_log.size()), 32'd16);
        chk("bp_req", 32'(oVRAM_READ_REQ), 32'd0);
        chk("bp_addr", 32'(oVRAM_READ_ADDR), 32'h10);

        // One pop frees a credit; WAIT holds address 0x10 for 5 cycles
        iDISP_REQ = 1'b1;
        iVRAM_WAIT = 1'b1;
        cyc();
        iDISP_REQ = 1'b0;
        chk("credit_req", 32'(oVRAM_READ_REQ), 32'd1);
        chk("credit_addr", 32'(oVRAM_READ_ADDR), 32'h10);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("wait_req_hold", 32'(oVRAM_READ_REQ), 32'd1);
            chk("wait_addr_hold", 32'(oVRAM_READ_ADDR), 32'h10);
        end
        iVRAM_WAIT = 1'b0;
        cyc();
        chk("wait_accept_req", 32'(oVRAM_READ_REQ), 32'd0);
        chk("wait_accept_addr", 32'(oVRAM_READ_ADDR), 32'h11);
        chk("wait_accept_count", 32'(req_log.size()), 32'd17);
        if (req_log.size() > 16) chk("wait_accept_value", 32'(req_log[16]), 32'h10);

        // Drain the buffered pixels 1..16 in order
        for (int i = 0; i < 32; i++) begin
            iDISP_REQ = (i % 2 == 0);
            cyc();
        end
        iDISP_REQ = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // Vsync mid-frame with three reads in flight
        lat = 3;
        pulse_vsync();
        chk("underrun_cleared", 32'(oDISP_UNDERRUN), 32'd0);
        cyc();
        cyc();
        pulse_vsync();
        req_log.delete();
        chk("mid_vsync_state", 32'(oDEBUG_STATE), ST_DRAIN);
        chk("mid_vsync_req", 32'(oVRAM_READ_REQ), 32'd0);
        n = 0;
        while (n < 10 && oDEBUG_STATE != 2'd1) begin
            cyc();
            n++;
        end
        chk("drain_cycles", 32'(n), 32'd3);
        iDISP_REQ = 1'b1;
        cyc();
        iDISP_REQ = 1'b0;
        chk("drain_fifo_empty_valid", 32'(oDISP_VALID), 32'd0);
        chk("drain_fifo_empty_underrun", 32'(oDISP_UNDERRUN), 32'd1);
        chk("restart_req_count", 32'(req_log.size()), 32'd1);
        if (req_log.size() > 0) chk("restart_addr", 32'(req_log[0]), 32'd0);
        for (int i = 0; i < 6; i++) cyc();
        iDISP_REQ = 1'b1;
        cyc();
        iDISP_REQ = 1'b0;
        chk("restart_first_pop", 32'(exp_q.size()), 32'(P_PIX - 1));

        // Scan-out disabled: DRAIN then IDLE, no requests
        lat = 2;
        iDISP_ENA = 1'b0;
        cyc();
        chk("ena_low_state", 32'(oDEBUG_STATE), ST_DRAIN);
        chk("ena_low_req", 32'(oVRAM_READ_REQ), 32'd0);
        n = 0;
        while (n < 10 && oDEBUG_STATE != 2'd0) begin
            cyc();
            n++;
        end
        chk("ena_low_idle", 32'(oDEBUG_STATE), ST_IDLE);
        chk("ena_low_req_idle", 32'(oVRAM_READ_REQ), 32'd0);
        chk("spurious_sticky", 32'(oERR_SPURIOUS), 32'd1);

        // Reset mid-frame
        iDISP_ENA = 1'b1;
        pulse_vsync();
        for (int i = 0; i < 200 && oVRAM_READ_ADDR < 19'd20; i++) begin
            iDISP_REQ = (i >= 8 && i % 2 == 0);
            cyc();
        end
        iDISP_REQ = 1'b0;
        chk("reach_addr20", 32'(oVRAM_READ_ADDR >= 19'd20), 32'd1);
        #2;
        iRESET = 1'b1;
        iVRAM_READ_VALID = 1'b0;
        due_a.delete();
        due_t.delete();
        exp_q.delete();
        #1;
        check_all_zero("async_reset");
        cyc();
        iRESET = 1'b0;
        cyc();
        chk("after_reset_state", 32'(oDEBUG_STATE), ST_IDLE);
        chk("after_reset_req", 32'(oVRAM_READ_REQ), 32'd0);

        // Recovery frame start
        pulse_vsync();
        for (int i = 0; i < 5; i++) cyc();
        iDISP_REQ = 1'b1;
        cyc();
        iDISP_REQ = 1'b0;
        chk("recover_first_pop", 32'(exp_q.size()), 32'(P_PIX - 1));
        chk("recover_underrun", 32'(oDISP_UNDERRUN), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gci_std_display_vram_reader.md
Name: gci_std_display_vram_reader

Overview:
- Read-side counterpart of the display command/VRAM write path.
- Scans the 640x480 16-bit (5R6G5B) VRAM frame in linear order, from address 0 to P_PIXELS-1.
- Issues pipelined VRAM read requests under a wait handshake and buffers the returned pixels in a credit-limited FIFO.
- Delivers one pixel per display-timing request, restarting on every frame-start pulse.

Parameters:
- P_PIXELS, 307200 (0x4B000): pixels per frame; last requested address is P_PIXELS-1.
- P_FIFO_DEPTH, 16: pixel FIFO entries; must be a power of 2.
- P_FIFO_DEPTH_N, 4: log2(P_FIFO_DEPTH).

Ports:
- iCLOCK  in  1  system clock; all logic is rising-edge.
- iRESET  in  1  asynchronous, active-high reset.
- iDISP_ENA  in  1  level; scan-out enabled.
- iDISP_VSYNC  in  1  one-cycle frame-start pulse.
- iDISP_REQ  in  1  pixel pop request from display timing.
- oDISP_VALID  out  1  pulse; oDISP_DATA holds a popped pixel.
- oDISP_DATA  out  16  pixel data (5R6G5B).
- oDISP_UNDERRUN  out  1  sticky; a pop occurred while the FIFO was empty.
- oVRAM_READ_REQ  out  1  read request.
- oVRAM_READ_ADDR  out  19  read address.
- iVRAM_WAIT  in  1  VRAM busy; the request is not accepted this cycle.
- iVRAM_READ_VALID  in  1  read data return, in order.
- iVRAM_READ_DATA  in  16  returned pixel.
- oERR_SPURIOUS  out  1  sticky; a return arrived with no read outstanding.

Behaviour:
- Reset values (iRESET high, asynchronous): all outputs 0, state IDLE, scan address 0, FIFO empty, outstanding count 0.
- Accept rule: a request is accepted when oVRAM_READ_REQ && !iVRAM_WAIT.
  - On accept, the scan address increments by 1 and outstanding increments by 1.
  - While waiting, oVRAM_READ_REQ and oVRAM_READ_ADDR hold stable.
- Issue condition (registered): state RUN && scan address < P_PIXELS && fifo_count + outstanding < P_FIFO_DEPTH.
  - fifo_count and outstanding are P_FIFO_DEPTH_N+1 bits wide; the FIFO can never overflow.
- Return: iVRAM_READ_VALID with outstanding > 0 pushes iVRAM_READ_DATA and decrements outstanding.
  - In state DRAIN the return is discarded instead of pushed.
  - With outstanding == 0 the return is dropped and oERR_SPURIOUS is set.
- Pop: iDISP_REQ with the FIFO non-empty makes oDISP_DATA registered to the head entry and oDISP_VALID = 1 on the next cycle (latency 1).
  - oDISP_DATA holds its value when no pop occurs.
  - iDISP_REQ with the FIFO empty gives oDISP_VALID = 0 next cycle and sets oDISP_UNDERRUN. There is no same-cycle push-to-pop bypass.
- Simultaneous push and pop: both occur and fifo_count is unchanged.
- State IDLE:
  - no requests;
  - iDISP_VSYNC && iDISP_ENA: scan address <= 0, FIFO flushed, oDISP_UNDERRUN cleared, next state RUN.
- State RUN:
  - requests are issued per the issue condition;
  - when scan address == P_PIXELS, stay in RUN and stop requesting until the next vsync;
  - iDISP_VSYNC: scan address <= 0, FIFO flushed, oDISP_UNDERRUN cleared; next state DRAIN if outstanding > 0 (counting any accept in the same cycle), else RUN;
  - iDISP_ENA low: next state DRAIN, with no further requests.
- State DRAIN:
  - no requests; returns are discarded;
  - when outstanding reaches 0: next state RUN if iDISP_ENA is high and a vsync occurred during entry or drain, else IDLE;
  - vsync arriving during DRAIN is latched.
- oVRAM_READ_REQ drops in the same cycle the state leaves RUN, or the scan address reaches P_PIXELS; no request is left half-issued.
- oERR_SPURIOUS is cleared only by iRESET. Reset mid-frame aborts immediately; the VRAM side is reset by the same iRESET.

Test Plan:
- Steady frame: iDISP_ENA = 1, vsync, iVRAM_WAIT = 0, 2-cycle return latency, iDISP_REQ every 4th cycle -> addresses 0..0x4AFFF each requested exactly once, pixels popped in order matching VRAM contents, oDISP_UNDERRUN stays 0.
- Backpressure: no iDISP_REQ after start -> requests stop with fifo_count + outstanding == 16; the FIFO holds pixels 0..15; a pop frees exactly one credit and the next address is 16.
- Wait handshake: iVRAM_WAIT high for 5 cycles at address 0x00010 -> oVRAM_READ_REQ and address 0x00010 held stable, accepted once when WAIT falls.
- Underrun: iDISP_REQ asserted the cycle after vsync with the FIFO empty -> oDISP_VALID = 0, oDISP_UNDERRUN = 1, cleared at the next vsync.
- Vsync mid-frame with 3 reads outstanding -> those 3 returns are discarded, the FIFO is empty, the next request is address 0x00000, and the first popped pixel is VRAM[0].
- Spurious return, and reset mid-frame: iVRAM_READ_VALID with outstanding == 0 -> oERR_SPURIOUS = 1 and the FIFO is unchanged; iRESET pulse at address 0x12345 -> all outputs 0 asynchronously, state IDLE.
